// File: rtl/synth_pkg.sv
// Shared constants and helpers for the FM operator datapath: phase/table sizing,
// sample format, quadrant encodings and the quarter-wave table generator.
package synth_pkg;

    localparam int PHASE_BITS    = 32'sd32;
    localparam int LUT_ADDR_BITS = 32'sd10;
    localparam int QUARTER_DEPTH = 32'sd1 << LUT_ADDR_BITS;
    localparam int SAMPLE_WI     = 32'sd2;
    localparam int SAMPLE_WF     = 32'sd16;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    // Half-step sampled quarter sine, scaled to 2^wf-1; evaluated only at elaboration.
    function automatic int quarter_sine_entry(input int idx, input int lut_bits, input int wf);
        real x;
        real term;
        real acc;
        real amp;
        x    = (real'(idx) + 0.5) * 3.14159265358979323846 / real'(64'd1 << (lut_bits + 32'sd1));
        term = x;
        acc  = x;
        for (int n = 32'sd1; n < 32'sd12; n++) begin
            term = -term * x * x / real'((32'sd2 * n) * (32'sd2 * n + 32'sd1));
            acc  = acc + term;
        end
        amp = real'((64'd1 << wf) - 64'd1);
        return $rtoi(acc * amp + 0.5);
    endfunction

endpackage

// File: rtl/operator_nco_if.sv
// Strobe/tuning inputs and sample outputs of one operator NCO.
interface operator_nco_if
    import synth_pkg::*;
#(
    parameter int NUM_BITS = PHASE_BITS,
    parameter int SAMPLE_W = SAMPLE_WI + SAMPLE_WF
);
    logic                acc_en;
    logic                phase_rst;
    logic [NUM_BITS-1:0] tuning_word;
    logic [SAMPLE_W-1:0] out_sample;
    logic                out_valid;

    modport master (
        output acc_en, phase_rst, tuning_word,
        input  out_sample, out_valid
    );

    modport slave (
        input  acc_en, phase_rst, tuning_word,
        output out_sample, out_valid
    );
endinterface

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine magnitude table with a registered (1-cycle) read port.
// Contents are computed at elaboration, so no memory init file is involved.
module sine_quarter_rom
    import synth_pkg::*;
#(
    parameter int LUT_BITS = LUT_ADDR_BITS,
    parameter int WF       = SAMPLE_WF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LUT_BITS-1:0] addr,
    output logic [WF-1:0]       data
);
    localparam int DEPTH = 32'sd1 << LUT_BITS;

    logic [WF-1:0] table_s [DEPTH];
    logic [WF-1:0] data_r;

    for (genvar i = 32'sd0; i < DEPTH; i++) begin : g_entry
        localparam logic [WF-1:0] ENTRY = WF'(quarter_sine_entry(i, LUT_BITS, WF));
        assign table_s[i] = ENTRY;
    end

    // Synchronous table read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r <= {WF{1'b0}};
        end else begin
            data_r <= table_s[addr];
        end
    end

    assign data = data_r;

endmodule

// File: rtl/operator_nco.sv
// FM operator oscillator: phase accumulator feeding a quarter-wave sine lookup,
// producing a signed WI.WF sample three edges after each accepted strobe.
module operator_nco
    import synth_pkg::*;
#(
    parameter int NUM_BITS = PHASE_BITS,
    parameter int LUT_BITS = LUT_ADDR_BITS,
    parameter int WI       = SAMPLE_WI,
    parameter int WF       = SAMPLE_WF
) (
    input  logic           clk,
    input  logic           rst,
    operator_nco_if.slave  bus
);
    localparam int SW = WI + WF;

    logic [NUM_BITS-1:0] phase_r;
    logic [NUM_BITS-1:0] phase_nxt_s;
    logic                v0_r;
    logic                v1_r;
    logic                v2_r;
    quadrant_t           quad0_s;
    logic [LUT_BITS-1:0] addr0_s;
    logic [LUT_BITS-1:0] addr_mirror_s;
    quadrant_t           quad1_r;
    logic [LUT_BITS-1:0] addr1_r;
    logic                neg1_s;
    logic                neg2_r;
    logic [WF-1:0]       mag2_s;
    logic [SW-1:0]       mag_ext_s;
    logic [SW-1:0]       signed_s;
    logic [SW-1:0]       sample_r;
    logic                valid_r;

    // Next phase: note-on sync beats the strobe; the add wraps naturally.
    always_comb begin
        phase_nxt_s = phase_r;
        if (bus.phase_rst) begin
            phase_nxt_s = {NUM_BITS{1'b0}};
        end else if (bus.acc_en) begin
            phase_nxt_s = phase_r + bus.tuning_word;
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Stage 0: phase register and strobe tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_r <= {NUM_BITS{1'b0}};
            v0_r    <= 1'b0;
        end else begin
            phase_r <= phase_nxt_s;
            v0_r    <= bus.acc_en;
        end
    end

    // Odd quadrants run the table backwards; the half-step table makes ~a exact.
    always_comb begin
        quad0_s       = quadrant_t'(phase_r[NUM_BITS-1 -: 2]);
        addr0_s       = phase_r[NUM_BITS-3 -: LUT_BITS];
        addr_mirror_s = addr0_s;
        case (quad0_s)
            Q0, Q2:  addr_mirror_s = addr0_s;
            Q1, Q3:  addr_mirror_s = ~addr0_s;
            default: addr_mirror_s = addr0_s;
        endcase
    end

    // Stage 1: quadrant and effective table address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quad1_r <= Q0;
            addr1_r <= {LUT_BITS{1'b0}};
            v1_r    <= 1'b0;
        end else begin
            quad1_r <= quad0_s;
            addr1_r <= addr_mirror_s;
            v1_r    <= v0_r;
        end
    end

    // Lower half of the cycle (quadrants 2 and 3) is negative.
    always_comb begin
        neg1_s = 1'b0;
        case (quad1_r)
            Q0, Q1:  neg1_s = 1'b0;
            Q2, Q3:  neg1_s = 1'b1;
            default: neg1_s = 1'b0;
        endcase
    end

    sine_quarter_rom #(
        .LUT_BITS (LUT_BITS),
        .WF       (WF)
    ) u_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (addr1_r),
        .data (mag2_s)
    );

    // Stage 2: sign travels alongside the table read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg2_r <= 1'b0;
            v2_r   <= 1'b0;
        end else begin
            neg2_r <= neg1_s;
            v2_r   <= v1_r;
        end
    end

    // Magnitude never reaches 2^WF, so negation cannot overflow.
    always_comb begin
        mag_ext_s = {{WI{1'b0}}, mag2_s};
        if (neg2_r) begin
            signed_s = ~mag_ext_s + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            signed_s = mag_ext_s;
        end
    end

    // Stage 3: output sample holds between valid pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_r <= {SW{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (v2_r) begin
                sample_r <= signed_s;
            end else begin
                sample_r <= sample_r;
            end
            valid_r <= v2_r;
        end
    end

    assign bus.out_sample = sample_r;
    assign bus.out_valid  = valid_r;

endmodule

// File: tb/tb_operator_nco.sv
// Directed bench for operator_nco: single-strobe vector table, phase sync without
// strobe, a full-period burst with antisymmetry and spot checks, and async reset.
module tb_operator_nco;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    operator_nco_if #(.NUM_BITS(32), .SAMPLE_W(18)) bus ();

    operator_nco #(
        .NUM_BITS (32),
        .LUT_BITS (10),
        .WI       (2),
        .WF       (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        prst;
        logic [31:0] tw;
        logic [17:0] exp;
    } vec_t;

    int          checks = 0;
    int          errs   = 0;
    vec_t        vecs [14];
    logic [17:0] samples [4096];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with an idle pipeline; issues one strobe and tracks it.
    task automatic strobe_and_check(input string nm, input logic prst, input logic [31:0] tw,
                                    input logic [17:0] exp);
        bus.acc_en      = 1'b1;
        bus.phase_rst   = prst;
        bus.tuning_word = tw;
        @(negedge clk);
        bus.acc_en    = 1'b0;
        bus.phase_rst = 1'b0;
        check({nm, " valid+1"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({nm, " valid+2"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({nm, " valid+3"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({nm, " valid"}, 32'(bus.out_valid), 32'd1);
        check({nm, " sample"}, 32'(bus.out_sample), 32'(exp));
        @(negedge clk);
        check({nm, " pulse end"}, 32'(bus.out_valid), 32'd0);
        check({nm, " hold"}, 32'(bus.out_sample), 32'(exp));
    endtask

    initial begin
        // Table values: ROM[0]=50, ROM[1]=151, ROM[255]=25033, ROM[256]=25126, ROM[1023]=65535.
        vecs[0]  = '{1'b1, 32'h0000_0000, 18'h00032};  // phase 0
        vecs[1]  = '{1'b0, 32'h4000_0000, 18'h0FFFF};  // 0x40000000, mirrored to 1023
        vecs[2]  = '{1'b1, 32'h0000_0000, 18'h00032};  // back to 0
        vecs[3]  = '{1'b0, 32'hC000_0000, 18'h30001};  // 0xC0000000 -> -65535
        vecs[4]  = '{1'b1, 32'hF000_0000, 18'h00032};  // sync wins over tuning word
        vecs[5]  = '{1'b0, 32'hF000_0000, 18'h39E37};  // 0xF0000000 -> -ROM[255]
        vecs[6]  = '{1'b0, 32'h2000_0000, 18'h06226};  // wrap to 0x10000000 -> ROM[256]
        vecs[7]  = '{1'b0, 32'h0000_0000, 18'h06226};  // zero step
        vecs[8]  = '{1'b0, 32'h7000_0000, 18'h3FFCE};  // 0x80000000 -> -ROM[0]
        vecs[9]  = '{1'b0, 32'h4000_0000, 18'h30001};  // 0xC0000000
        vecs[10] = '{1'b0, 32'h4010_0000, 18'h00097};  // wrap to 0x00100000 -> ROM[1]
        vecs[11] = '{1'b0, 32'h7FF0_0000, 18'h3FFCE};  // 0x80000000
        vecs[12] = '{1'b0, 32'h000F_FFFF, 18'h3FFCE};  // 0x800FFFFF, low bits truncated
        vecs[13] = '{1'b0, 32'h3FF0_0001, 18'h30001};  // 0xC0000000

        bus.acc_en      = 1'b0;
        bus.phase_rst   = 1'b0;
        bus.tuning_word = 32'h0;
        rst             = 1'b0;
        repeat (3) @(negedge clk);
        check("reset valid", 32'(bus.out_valid), 32'd0);
        check("reset sample", 32'(bus.out_sample), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            strobe_and_check($sformatf("vec%0d", i), vecs[i].prst, vecs[i].tw, vecs[i].exp);
        end

        // Sync without a strobe: phase zeroed, no sample emitted.
        bus.phase_rst   = 1'b1;
        bus.tuning_word = 32'h1234_5678;
        @(negedge clk);
        bus.phase_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("sync-only no valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        strobe_and_check("after sync-only", 1'b0, 32'h0, 18'h00032);

        // Full period, one strobe per cycle.
        for (int i = 0; i < 4100; i++) begin
            @(negedge clk);
            if (i >= 4) begin
                check($sformatf("burst valid %0d", i), 32'(bus.out_valid), 32'd1);
                samples[i-4] = bus.out_sample;
            end else begin
                check($sformatf("burst fill %0d", i), 32'(bus.out_valid), 32'd0);
            end
            if (i < 4096) begin
                bus.acc_en      = 1'b1;
                bus.phase_rst   = (i == 0);
                bus.tuning_word = (i == 0) ? 32'h0 : 32'h0010_0000;
            end else begin
                bus.acc_en    = 1'b0;
                bus.phase_rst = 1'b0;
            end
        end
        @(negedge clk);
        check("burst drained", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 2048; k++) begin
            logic [17:0] neg;
            neg = -samples[k];
            check($sformatf("antisym %0d", k), 32'(samples[k+2048]), 32'(neg));
        end
        check("burst k0", 32'(samples[0]), 32'h00032);
        check("burst k1", 32'(samples[1]), 32'h00097);
        check("burst k256", 32'(samples[256]), 32'h06226);
        check("burst k1024", 32'(samples[1024]), 32'h0FFFF);
        check("burst k3072", 32'(samples[3072]), 32'h30001);
        check("burst k4095", 32'(samples[4095]), 32'h3FFCE);

        // Async reset in the middle of a burst.
        bus.acc_en      = 1'b1;
        bus.phase_rst   = 1'b1;
        bus.tuning_word = 32'h0;
        @(negedge clk);
        bus.phase_rst   = 1'b0;
        bus.tuning_word = 32'h4000_0000;
        repeat (4) @(negedge clk);
        check("pre-reset valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async reset valid", 32'(bus.out_valid), 32'd0);
        check("async reset sample", 32'(bus.out_sample), 32'd0);
        @(negedge clk);
        bus.acc_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post-reset no valid", 32'(bus.out_valid), 32'd0);
        end
        strobe_and_check("post-reset strobe", 1'b0, 32'h4000_0000, 18'h0FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule
